// File: rtl/cond_pkg.sv
// cond_pkg -- shared definitions for the condition/status unit.
//   cond_t    : 4-bit condition codes evaluated against the committed flags
//   state_t   : query FSM states
//   FLAG_*    : bit positions of N, Z, I, V within the 32-bit flags word
//   sat_inc8  : 8-bit increment that sticks at 255
package cond_pkg;

   localparam int FLAG_N = 31;
   localparam int FLAG_Z = 30;
   localparam int FLAG_I = 29;
   localparam int FLAG_V = 28;

   typedef enum logic [3:0] {
      EQ     = 4'h0,
      NE     = 4'h1,
      IS     = 4'h2,
      IC     = 4'h3,
      MI     = 4'h4,
      PL     = 4'h5,
      VS     = 4'h6,
      VC     = 4'h7,
      GT     = 4'h8,
      LE     = 4'h9,
      GE     = 4'hA,
      LT     = 4'hB,
      RSVD_C = 4'hC,
      RSVD_D = 4'hD,
      AL     = 4'hE,
      NV     = 4'hF
   } cond_t;

   typedef enum logic {
      ST_READY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval -- purely combinational condition table.
//   cond    : condition code (cond_t encoding)
//   n,z,i,v : committed flags
//   pass    : 1 when the condition holds; reserved codes C/D never pass
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       n,
   input  logic       z,
   input  logic       i,
   input  logic       v,
   output logic       pass
);

   always_comb begin
      pass = 1'b0;
      case (cond_t'(cond))
         EQ:     pass = z;
         NE:     pass = ~z;
         IS:     pass = i;
         IC:     pass = ~i;
         MI:     pass = n;
         PL:     pass = ~n;
         VS:     pass = v;
         VC:     pass = ~v;
         GT:     pass = ~z & (n == v);
         LE:     pass = z | (n != v);
         GE:     pass = (n == v);
         LT:     pass = (n != v);
         RSVD_C: pass = 1'b0;
         RSVD_D: pass = 1'b0;
         AL:     pass = 1'b1;
         NV:     pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_status_unit.sv
// cond_status_unit -- committed ALU status register, condition query port and
// sticky invalid/overflow counters.
//   clk, rst_n              : clock, asynchronous active-low reset
//   flags_in, flags_valid   : ALU flags word (N,Z,I,V in bits 31:28) and qualifier
//   set_flags               : with flags_valid, commit flags_in[31:28]
//   cond, cond_valid        : condition query request
//   cond_ready              : query may be accepted this cycle
//   cond_pass(_valid)       : held query result
//   cond_ack                : consumer takes the held result
//   status_out              : committed flags in 31:28, zeros elsewhere
//   inv_count, ovf_count    : saturating counts of results with I / V set
//   clear_sticky            : synchronous clear of both counters
//
// Handshakes: a query transfers on a rising edge where cond_valid & cond_ready
// are both 1; the requester may drop cond_valid while cond_ready is 0 and the
// request is then simply gone. A result is offered while cond_pass_valid is 1
// and is retired on the edge where cond_ack is 1; cond_ack at any other time
// has no effect.
module cond_status_unit
   import cond_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] flags_in,
   input  logic        flags_valid,
   input  logic        set_flags,
   input  logic [3:0]  cond,
   input  logic        cond_valid,
   output logic        cond_ready,
   output logic        cond_pass,
   output logic        cond_pass_valid,
   input  logic        cond_ack,
   output logic [31:0] status_out,
   output logic [7:0]  inv_count,
   output logic [7:0]  ovf_count,
   input  logic        clear_sticky
);

   state_t     state, state_nxt;
   logic [3:0] flags_q;       // {N, Z, I, V}
   logic       pass_q;
   logic       eval_pass;
   logic       commit;
   logic       accept;
   logic [7:0] inv_q, ovf_q;
   logic       unused_flags;

   assign commit       = flags_valid & set_flags;
   assign unused_flags = ^flags_in[FLAG_V-1:0];

   cond_eval u_cond_eval (
      .cond (cond),
      .n    (flags_q[3]),
      .z    (flags_q[2]),
      .i    (flags_q[1]),
      .v    (flags_q[0]),
      .pass (eval_pass)
   );

   // A query accepted together with a commit would be ambiguous about which
   // flags it sees, so acceptance is stalled for that cycle; the query then
   // evaluates the freshly committed flags one cycle later.
   always_comb begin
      state_nxt  = state;
      cond_ready = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_READY: begin
            cond_ready = ~commit;
            if (cond_valid && !commit) begin
               accept    = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cond_ack) state_nxt = ST_READY;
         end
         default: state_nxt = ST_READY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_READY;
      else        state <= state_nxt;
   end

   // Result is captured only on acceptance, so later commits in HOLD cannot
   // disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pass_q <= 1'b0;
      else if (accept) pass_q <= eval_pass;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      flags_q <= 4'd0;
      else if (commit) flags_q <= {flags_in[FLAG_N], flags_in[FLAG_Z],
                                   flags_in[FLAG_I], flags_in[FLAG_V]};
   end

   // Counters see every ALU result, committed or not; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_q <= 8'd0;
         ovf_q <= 8'd0;
      end else if (clear_sticky) begin
         inv_q <= 8'd0;
         ovf_q <= 8'd0;
      end else if (flags_valid) begin
         if (flags_in[FLAG_I]) inv_q <= sat_inc8(inv_q);
         if (flags_in[FLAG_V]) ovf_q <= sat_inc8(ovf_q);
      end
   end

   assign cond_pass       = pass_q;
   assign cond_pass_valid = (state == ST_HOLD);
   assign status_out      = {flags_q, 28'd0};
   assign inv_count       = inv_q;
   assign ovf_count       = ovf_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// tb_cond_status_unit -- directed scenarios followed by random traffic, all
// checked against a behavioural model of the status unit.
module tb_cond_status_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] flags_in = '0;
   logic        flags_valid = 1'b0;
   logic        set_flags = 1'b0;
   logic [3:0]  cond = '0;
   logic        cond_valid = 1'b0;
   logic        cond_ready;
   logic        cond_pass;
   logic        cond_pass_valid;
   logic        cond_ack = 1'b0;
   logic [31:0] status_out;
   logic [7:0]  inv_count;
   logic [7:0]  ovf_count;
   logic        clear_sticky = 1'b0;

   cond_status_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flags_in        (flags_in),
      .flags_valid     (flags_valid),
      .set_flags       (set_flags),
      .cond            (cond),
      .cond_valid      (cond_valid),
      .cond_ready      (cond_ready),
      .cond_pass       (cond_pass),
      .cond_pass_valid (cond_pass_valid),
      .cond_ack        (cond_ack),
      .status_out      (status_out),
      .inv_count       (inv_count),
      .ovf_count       (ovf_count),
      .clear_sticky    (clear_sticky)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   logic [3:0] m_nzvi;        // {N, Z, I, V}
   bit         m_hold;
   int         m_inv, m_ovf;
   logic [0:0] exp_q[$];      // expected result of the query being held

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Condition rules applied directly to the four flags.
   function automatic logic ref_eval(input logic [3:0] f, input logic [3:0] c);
      logic n, z, i, v;
      logic [15:0] t;
      n = f[3]; z = f[2]; i = f[1]; v = f[0];
      t = '0;
      t[0]  = z;          t[1]  = !z;
      t[2]  = i;          t[3]  = !i;
      t[4]  = n;          t[5]  = !n;
      t[6]  = v;          t[7]  = !v;
      t[8]  = !z && (n == v);
      t[9]  = z || (n != v);
      t[10] = (n == v);   t[11] = (n != v);
      t[14] = 1'b1;
      return t[c];
   endfunction

   task automatic model_reset();
      m_nzvi = '0; m_hold = 0; m_inv = 0; m_ovf = 0;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_status"}, status_out, {m_nzvi, 28'd0});
      check({tag, "_valid"}, {31'd0, cond_pass_valid}, {31'd0, m_hold});
      if (m_hold && exp_q.size() > 0)
         check({tag, "_pass"}, {31'd0, cond_pass}, {31'd0, exp_q[0]});
      check({tag, "_inv"}, {24'd0, inv_count}, m_inv);
      check({tag, "_ovf"}, {24'd0, ovf_count}, m_ovf);
   endtask

   // One clock cycle: drive inputs just after an edge, check the combinational
   // ready, advance the model across the edge, then check registered outputs.
   task automatic apply(input string tag, input bit fv, input bit sf, input logic [31:0] fl,
                        input bit cv, input logic [3:0] c, input bit ack, input bit clr);
      bit exp_ready, acc;
      flags_valid = fv; set_flags = sf; flags_in = fl;
      cond_valid = cv; cond = c; cond_ack = ack; clear_sticky = clr;
      #1;
      exp_ready = !m_hold && !(fv && sf);
      check({tag, "_ready"}, {31'd0, cond_ready}, {31'd0, exp_ready});
      acc = cv && exp_ready;
      @(posedge clk);
      if (m_hold && ack) begin
         m_hold = 0;
         void'(exp_q.pop_front());
      end else if (acc) begin
         exp_q.push_back(ref_eval(m_nzvi, c));
         m_hold = 1;
      end
      if (fv && sf) m_nzvi = {fl[31], fl[30], fl[29], fl[28]};
      if (clr) begin
         m_inv = 0; m_ovf = 0;
      end else if (fv) begin
         if (fl[29] && m_inv < 255) m_inv++;
         if (fl[28] && m_ovf < 255) m_ovf++;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      apply(tag, 0, 0, 32'd0, 0, 4'd0, 0, 0);
   endtask

   task automatic query(input string tag, input logic [3:0] c);
      apply(tag, 0, 0, 32'd0, 1, c, 0, 0);
   endtask

   task automatic ack(input string tag);
      apply(tag, 0, 0, 32'd0, 0, 4'd0, 1, 0);
   endtask

   task automatic commit(input string tag, input logic [31:0] fl);
      apply(tag, 1, 1, fl, 0, 4'd0, 0, 0);
   endtask

   // Drops reset while mid-cycle and checks the asynchronous clear.
   task automatic pulse_reset(input string tag);
      flags_valid = 0; set_flags = 0; cond_valid = 0; cond_ack = 0; clear_sticky = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_status"}, status_out, 32'd0);
      check({tag, "_rst_pass"}, {31'd0, cond_pass}, 32'd0);
      check({tag, "_rst_valid"}, {31'd0, cond_pass_valid}, 32'd0);
      check({tag, "_rst_inv"}, {24'd0, inv_count}, 32'd0);
      check({tag, "_rst_ovf"}, {24'd0, ovf_count}, 32'd0);
      model_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle({tag, "_post"});
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] codes[8]   = '{4'h8, 4'hB, 4'hA, 4'h9, 4'hE, 4'hF, 4'hC, 4'hD};
   logic       code_exp[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      model_reset();
      pulse_reset("init");

      // Z commit then EQ query, result one cycle after acceptance
      commit("c31", 32'h4000_0000);
      check("c31_status_const", status_out, 32'h4000_0000);
      query("c31_q", 4'h0);
      check("c31_pass_const", {31'd0, cond_pass}, 32'd1);
      check("c31_valid_const", {31'd0, cond_pass_valid}, 32'd1);
      ack("c31_ack");

      // Commit hazard stall: NE query stalled, then sees the new Z=1
      commit("c32_pre", 32'h0000_0000);
      apply("c32_stall", 1, 1, 32'h4000_0000, 1, 4'h1, 0, 0);
      check("c32_no_result", {31'd0, cond_pass_valid}, 32'd0);
      query("c32_acc", 4'h1);
      check("c32_pass_const", {31'd0, cond_pass}, 32'd0);
      ack("c32_ack");

      // Signed compares with N=1, V=0, Z=0
      commit("c33", 32'h8000_0000);
      for (int k = 0; k < 8; k++) begin
         query("c33_q", codes[k]);
         check("c33_code_const", {31'd0, cond_pass}, {31'd0, code_exp[k]});
         ack("c33_ack");
      end

      // Held result survives commits
      commit("c34_pre", 32'h4000_0000);
      query("c34_q", 4'h0);
      for (int k = 0; k < 5; k++)
         commit("c34_hold", 32'h0000_0000 | ($urandom_range(0, 15) << 28));
      check("c34_pass_const", {31'd0, cond_pass}, 32'd1);
      ack("c34_ack");
      idle("c34_ready");

      // Overflow counter saturation and clear precedence
      commit("c35_pre", 32'hA000_0000);
      for (int k = 0; k < 260; k++)
         apply("c35_inc", 1, 0, 32'h1000_0000, 0, 4'd0, 0, 0);
      check("c35_sat_const", {24'd0, ovf_count}, 32'd255);
      check("c35_status_const", status_out, 32'hA000_0000);
      apply("c35_clr", 1, 0, 32'h3000_0000, 0, 4'd0, 0, 1);
      check("c35_clr_const", {24'd0, ovf_count}, 32'd0);

      // Reset while holding a result
      commit("c36_pre", 32'h4000_0000);
      query("c36_q", 4'h0);
      idle("c36_hold");
      pulse_reset("c36");
      check("c36_ready_const", {31'd0, cond_ready}, 32'd1);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] fl;
         fl = $urandom();
         apply("rnd", $urandom_range(0, 1), $urandom_range(0, 3) == 0, fl,
               $urandom_range(0, 1), 4'($urandom_range(0, 15)),
               $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cond_status_unit.md
COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset; clk and rst_n listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flags_in  input  32  ALU flags word: bit31 N, bit30 Z, bit29 I (invalid/div-by-zero), bit28 V; other bits ignored.
REQ-005 flags_valid  input  1  flags_in qualifies this cycle (one ALU result).
REQ-006 set_flags  input  1  S-bit; with flags_valid, commit flags_in[31:28] to status register.
REQ-007 cond  input  4  condition code to evaluate.
REQ-008 cond_valid  input  1  query request; transfers when cond_valid & cond_ready.
REQ-009 cond_ready  output  1  query can be accepted this cycle.
REQ-010 cond_pass  output  1  evaluation result; meaningful only while cond_pass_valid.
REQ-011 cond_pass_valid  output  1  result held until consumer acknowledges.
REQ-012 cond_ack  input  1  consumer takes result; effective only while cond_pass_valid.
REQ-013 status_out  output  32  committed flags in bits 31:28, all other bits 0.
REQ-014 inv_count, ovf_count  output  8 each  saturating counts of results with I / V set.
REQ-015 clear_sticky  input  1  synchronous clear of both counters.

Function
REQ-016 Flag commit: flags_valid & set_flags at edge k SHALL update status_out[31:28] visible after edge k; flags_valid without set_flags SHALL leave status unchanged.
REQ-017 Condition table (N,Z,I,V from committed status) SHALL be: 0 EQ Z; 1 NE !Z; 2 IS I; 3 IC !I; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 GT !Z&(N==V); 9 LE Z|(N!=V); A GE N==V; B LT N!=V; C,D reserved -> 0; E AL -> 1; F NV -> 0.
REQ-018 FSM states SHALL be READY and HOLD; reset state READY.
REQ-019 In READY, cond_ready SHALL be 1 except when flags_valid & set_flags is asserted in the same cycle (commit hazard stall).
REQ-020 Accepted query at edge k SHALL register cond_pass from status committed before edge k, assert cond_pass_valid after edge k (latency 1), move to HOLD.
REQ-021 In HOLD, cond_ready SHALL be 0 and cond_pass stable; cond_ack SHALL return to READY at next edge.
REQ-022 A stalled query SHALL be accepted the following cycle if no new commit, evaluating the newly committed flags.
REQ-023 cond_ack while not cond_pass_valid SHALL be ignored; cond_valid dropped during stall SHALL be discarded with no result.
REQ-024 On every flags_valid (independent of set_flags), inv_count SHALL +1 if flags_in[29], ovf_count +1 if flags_in[28], saturating at 255.
REQ-025 clear_sticky SHALL take precedence over a simultaneous increment (counter becomes 0).
REQ-026 Flag commits SHALL proceed in HOLD without altering the held cond_pass.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state READY, status_out 0, cond_pass 0, cond_pass_valid 0, counters 0; cond_ready SHALL be 1 after reset deasserts.
REQ-028 Reset mid-HOLD SHALL drop the pending result with no ack required.

Structure
REQ-029 Shared package cond_pkg SHALL hold the condition-code enum (EQ..NV), flag bit positions (FLAG_N=31, FLAG_Z=30, FLAG_I=29, FLAG_V=28) and FSM state typedef.
REQ-030 Condition table SHALL be a combinational sub-module cond_eval (cond, N, Z, I, V -> pass).

Verification
REQ-031 Reset, then commit flags_in=32'h4000_0000 with set_flags -> status_out=32'h4000_0000; query EQ -> cond_pass=1, cond_pass_valid one cycle after acceptance.
REQ-032 Commit with set_flags and cond_valid (cond=NE) same cycle, status previously Z=0, new Z=1 -> cond_ready=0 that cycle; accepted next cycle; cond_pass=0.
REQ-033 N=1,V=0,Z=0 committed -> GT=0, LT=1, GE=0, LE=1; AL=1, NV=0, codes C/D=0.
REQ-034 Hold result 5 cycles without cond_ack while committing new flags -> cond_pass unchanged, cond_ready=0; ack -> READY next cycle.
REQ-035 260 flags_valid with bit28 set (set_flags=0) -> ovf_count=255, status_out unchanged; clear_sticky with simultaneous increment -> 0.
REQ-036 Assert rst_n low during HOLD -> all outputs 0 immediately, cond_ready=1 after release.
